// File: rtl/fpcmult_sched_pkg.sv
// rtl/fpcmult_sched_pkg.sv - shared types and sizing helpers for the multiplier scheduler
package fpcmult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam int DONE_CNT_W = 16;

  // Grant index width; a single requester still needs a 1-bit index.
  function automatic int gw(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/fpcmult_rr_arbiter.sv
// rtl/fpcmult_rr_arbiter.sv - combinational round-robin pick starting at ptr
module fpcmult_rr_arbiter
  import fpcmult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = gw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [GW-1:0]   grant_idx,
  output logic            any_grant
);

  localparam int SW = GW + 1;

  logic [SW-1:0] slot;

  // Walk from the far end back toward ptr so the nearest requester wins last.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    slot      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      slot = {1'b0, ptr} + SW'(k);
      if (slot >= SW'(NREQ)) begin
        slot = slot - SW'(NREQ);
      end
      if (req[slot[GW-1:0]]) begin
        grant_oh                = '0;
        grant_oh[slot[GW-1:0]]  = 1'b1;
        grant_idx               = slot[GW-1:0];
        any_grant               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpcmult_rr_scheduler.sv
// rtl/fpcmult_rr_scheduler.sv - round-robin sharing of one iterative complex multiplier
module fpcmult_rr_scheduler
  import fpcmult_sched_pkg::*;
#(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_val,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ*n-1:0]     req_ar,
  input  logic [NREQ*n-1:0]     req_ac,
  input  logic [NREQ*n-1:0]     req_br,
  input  logic [NREQ*n-1:0]     req_bc,
  output logic [NREQ-1:0]       resp_val,
  input  logic [NREQ-1:0]       resp_rdy,
  output logic [n-1:0]          resp_cr,
  output logic [n-1:0]          resp_cc,
  output logic                  mul_recv_val,
  input  logic                  mul_recv_rdy,
  output logic [n-1:0]          mul_ar,
  output logic [n-1:0]          mul_ac,
  output logic [n-1:0]          mul_br,
  output logic [n-1:0]          mul_bc,
  input  logic                  mul_send_val,
  output logic                  mul_send_rdy,
  input  logic [n-1:0]          mul_cr,
  input  logic [n-1:0]          mul_cc,
  output logic [DONE_CNT_W-1:0] done_count
);

  localparam int GW = gw(NREQ);

  // Fraction bits are only a label on the data; they must fit inside the word.
  if (d > n) begin : g_bad_frac
    $error("fractional bits exceed operand width");
  end

  sched_state_e          state_q, state_d;
  logic [GW-1:0]         ptr_q, grant_q;
  logic [n-1:0]          ar_q, ac_q, br_q, bc_q, cr_q, cc_q;
  logic [DONE_CNT_W-1:0] done_count_q;

  logic [NREQ-1:0] win_oh;
  logic [GW-1:0]   win_idx;
  logic            win_any;
  logic            accept, issued, returned, retired;

  fpcmult_rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
    .req       (req_val),
    .ptr       (ptr_q),
    .grant_oh  (win_oh),
    .grant_idx (win_idx),
    .any_grant (win_any)
  );

  always_comb begin
    state_d      = state_q;
    req_rdy      = '0;
    resp_val     = '0;
    mul_recv_val = 1'b0;
    mul_send_rdy = 1'b0;
    accept       = 1'b0;
    issued       = 1'b0;
    returned     = 1'b0;
    retired      = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = win_oh;
        accept  = win_any;
        if (win_any) state_d = ISSUE;
      end
      ISSUE: begin
        mul_recv_val = 1'b1;
        issued       = mul_recv_rdy;
        if (mul_recv_rdy) state_d = WAIT;
      end
      WAIT: begin
        mul_send_rdy = 1'b1;
        returned     = mul_send_val;
        if (mul_send_val) state_d = RESP;
      end
      RESP: begin
        resp_val[grant_q] = 1'b1;
        retired           = resp_rdy[grant_q];
        if (resp_rdy[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      ar_q         <= '0;
      ac_q         <= '0;
      br_q         <= '0;
      bc_q         <= '0;
      cr_q         <= '0;
      cc_q         <= '0;
      done_count_q <= '0;
    end else begin
      state_q <= state_d;
      // Operands are sampled only on the winner's req_rdy cycle.
      if (accept) begin
        grant_q <= win_idx;
        ar_q    <= req_ar[win_idx*n +: n];
        ac_q    <= req_ac[win_idx*n +: n];
        br_q    <= req_br[win_idx*n +: n];
        bc_q    <= req_bc[win_idx*n +: n];
      end
      if (returned) begin
        cr_q <= mul_cr;
        cc_q <= mul_cc;
      end
      if (retired) begin
        ptr_q        <= (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
        done_count_q <= done_count_q + DONE_CNT_W'(1);
      end
    end
  end

  // issued is folded into the FSM; it is kept for readability of the handshake.
  logic unused_issued;
  assign unused_issued = issued;

  assign mul_ar     = ar_q;
  assign mul_ac     = ac_q;
  assign mul_br     = br_q;
  assign mul_bc     = bc_q;
  assign resp_cr    = cr_q;
  assign resp_cc    = cc_q;
  assign done_count = done_count_q;

endmodule
